// File: rtl/sec_sdrd_deser.sv
// sec_sdrd_deser
//   Captures the security-sequencer PAL serial response bit (SDRD) on every
//   qualified access strobe. It assembles WIDTH bits into a parallel word and
//   hands completed words to the host register file over valid/ready.
//
// Optional build macro: SEC_SDRD_TIMEOUT_EN
//   When defined, a partial frame is discarded after TIMEOUT_CYC idle cycles
//   without a strobe. When undefined, a partial frame persists indefinitely.
//
// Ports
//   clk        in         system clock, all logic on posedge
//   rst        in         synchronous reset, active-high
//   acc_stb    in         qualified access strobe (each high cycle is a strobe)
//   sdrd_oe    in         PAL is driving SDRD during this access
//   sdrd_in    in         serial response bit, sampled only with acc_stb
//   byte_out   out WIDTH  assembled word, stable while byte_valid=1
//   byte_valid out        word available
//   byte_ready in         consumer accepts word on byte_valid & byte_ready
//   bit_cnt    out 5      bits collected in the current frame (0..WIDTH-1)
//   overrun    out        sticky: a completed word was dropped
//   clr_ovr    in         clears overrun (a same-cycle set wins)
//   frame_err  out        one-cycle pulse: partial frame discarded
module sec_sdrd_deser #(
  parameter int WIDTH       = 8,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_stb,
  input  logic             sdrd_oe,
  input  logic             sdrd_in,
  output logic [WIDTH-1:0] byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [4:0]       bit_cnt,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic             frame_err
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             take_bit;
  logic             resync;
  logic             last_bit;
  logic             word_done;
  logic             tmo_expire;

  assign take_bit  = acc_stb & sdrd_oe;
  assign resync    = acc_stb & ~sdrd_oe;
  assign last_bit  = (bit_cnt == 5'(WIDTH - 1));
  assign word_done = take_bit & last_bit;

  // Bit order: shifting toward the LSB leaves the first captured bit in
  // word[0] after WIDTH shifts. Shifting toward the MSB leaves it in
  // word[WIDTH-1].
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], sdrd_in};
    end else begin : g_lsb_first
      assign shift_next = {sdrd_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

`ifdef SEC_SDRD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt_reg;

  // Expiry fires on the TIMEOUT_CYC-th idle cycle in SHIFT.
  // A strobe in that same cycle takes precedence.
  assign tmo_expire = (state_reg == SHIFT) && !acc_stb &&
                      (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || acc_stb || tmo_expire || state_reg != SHIFT) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // A resync in IDLE has nothing to discard, so it raises no error.
      frame_err <= (resync && bit_cnt != 5'd0) || tmo_expire;

      // Frame assembly
      if (take_bit) begin
        if (last_bit) begin
          shift_reg <= '0;
          bit_cnt   <= '0;
          state_reg <= IDLE;
        end else begin
          shift_reg <= shift_next;
          bit_cnt   <= bit_cnt + 5'd1;
          state_reg <= SHIFT;
        end
      end else if (resync || tmo_expire) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        state_reg <= IDLE;
      end

      // The holding register accepts a new word whenever the old one is gone
      // or is being consumed in this same cycle.
      if (word_done && (!byte_valid || byte_ready)) begin
        byte_out   <= shift_next;
        byte_valid <= 1'b1;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      if (word_done && byte_valid && !byte_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sec_sdrd_deser.sv
// Directed bench for sec_sdrd_deser.
// Two instances share the stimulus: dut_l uses LSB-first order and dut_m uses MSB-first order.
module tb_sec_sdrd_deser;
  logic       clk = 1'b0;
  logic       rst, acc_stb, sdrd_oe, sdrd_in, byte_ready, clr_ovr;
  logic [7:0] out_l, out_m;
  logic       valid_l, valid_m, ovr_l, ovr_m, ferr_l, ferr_m;
  logic [4:0] cnt_l, cnt_m;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  sec_sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT_CYC(16)) dut_l (
    .clk(clk), .rst(rst), .acc_stb(acc_stb), .sdrd_oe(sdrd_oe), .sdrd_in(sdrd_in),
    .byte_out(out_l), .byte_valid(valid_l), .byte_ready(byte_ready), .bit_cnt(cnt_l),
    .overrun(ovr_l), .clr_ovr(clr_ovr), .frame_err(ferr_l));

  sec_sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT_CYC(16)) dut_m (
    .clk(clk), .rst(rst), .acc_stb(acc_stb), .sdrd_oe(sdrd_oe), .sdrd_in(sdrd_in),
    .byte_out(out_m), .byte_valid(valid_m), .byte_ready(byte_ready), .bit_cnt(cnt_m),
    .overrun(ovr_m), .clr_ovr(clr_ovr), .frame_err(ferr_m));

  // Inputs change 1ns after an edge, and outputs are sampled at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    acc_stb = 1'b1; sdrd_oe = 1'b1; sdrd_in = b;
    cycle();
    acc_stb = 1'b0; sdrd_oe = 1'b0; sdrd_in = 1'b0;
  endtask

  // Sends bits LSB-first from a byte value (b[0] goes first).
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1; acc_stb = 1'b0; sdrd_oe = 1'b0; sdrd_in = 1'b0;
    byte_ready = 1'b0; clr_ovr = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (out_l !== 8'h00) begin fails++; $display("FAIL reset_byte_out: got %h want 00", out_l); end
    tests++; if (valid_l !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_l); end
    tests++; if (cnt_l !== 5'd0) begin fails++; $display("FAIL reset_bit_cnt: got %0d want 0", cnt_l); end
    tests++; if (ovr_l !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", ovr_l); end
    tests++; if (ferr_l !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", ferr_l); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_bit_order();
    logic [7:0] bits;
    bits = 8'b0100_1101;  // sequence 1,0,1,1,0,0,1,0
    do_reset();
    for (int i = 0; i < 7; i++) send_bit(bits[i]);
    tests++; if (cnt_l !== 5'd7) begin fails++; $display("FAIL order_cnt7: got %0d want 7", cnt_l); end
    tests++; if (valid_l !== 1'b0) begin fails++; $display("FAIL order_early_valid: got %b want 0", valid_l); end
    send_bit(bits[7]);
    tests++; if (out_l !== 8'h4D) begin fails++; $display("FAIL lsb_first_word: got %h want 4d", out_l); end
    tests++; if (valid_l !== 1'b1) begin fails++; $display("FAIL lsb_first_valid: got %b want 1", valid_l); end
    tests++; if (cnt_l !== 5'd0) begin fails++; $display("FAIL order_cnt_wrap: got %0d want 0", cnt_l); end
    tests++; if (out_m !== 8'hB2) begin fails++; $display("FAIL msb_first_word: got %h want b2", out_m); end
    tests++; if (valid_m !== 1'b1) begin fails++; $display("FAIL msb_first_valid: got %b want 1", valid_m); end
    byte_ready = 1'b1;
    cycle();
    byte_ready = 1'b0;
    tests++; if (valid_m !== 1'b0) begin fails++; $display("FAIL handshake_drop_m: got %b want 0", valid_m); end
    tests++; if (valid_l !== 1'b0) begin fails++; $display("FAIL handshake_drop_l: got %b want 0", valid_l); end
    $display("[TB] test_bit_order lsb=%h msb=%h", out_l, out_m);
  endtask

  task automatic test_overrun();
    do_reset();
    send_byte(8'h4D);
    send_byte(8'hFF);
    tests++; if (out_l !== 8'h4D) begin fails++; $display("FAIL overrun_keep_old: got %h want 4d", out_l); end
    tests++; if (ovr_l !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", ovr_l); end
    tests++; if (valid_l !== 1'b1) begin fails++; $display("FAIL overrun_valid: got %b want 1", valid_l); end
    clr_ovr = 1'b1;
    cycle();
    clr_ovr = 1'b0;
    tests++; if (ovr_l !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b want 0", ovr_l); end
    // Set and clear requested in the same cycle: set wins.
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    clr_ovr = 1'b1;
    send_bit(1'b1);
    clr_ovr = 1'b0;
    tests++; if (ovr_l !== 1'b1) begin fails++; $display("FAIL overrun_set_wins: got %b want 1", ovr_l); end
    $display("[TB] test_overrun byte_out=%h", out_l);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_byte(8'h4D);
    for (int i = 0; i < 7; i++) send_bit(1'(8'hA5 >> i));
    byte_ready = 1'b1;
    send_bit(1'b1);  // bit 7 of A5 completes the word as 4D is consumed
    byte_ready = 1'b0;
    tests++; if (out_l !== 8'hA5) begin fails++; $display("FAIL b2b_new_word: got %h want a5", out_l); end
    tests++; if (valid_l !== 1'b1) begin fails++; $display("FAIL b2b_valid_held: got %b want 1", valid_l); end
    tests++; if (ovr_l !== 1'b0) begin fails++; $display("FAIL b2b_no_overrun: got %b want 0", ovr_l); end
    $display("[TB] test_back_to_back byte_out=%h", out_l);
  endtask

  task automatic test_resync();
    do_reset();
    // A resync in IDLE must not raise frame_err.
    acc_stb = 1'b1; sdrd_oe = 1'b0;
    cycle();
    acc_stb = 1'b0;
    tests++; if (ferr_l !== 1'b0) begin fails++; $display("FAIL resync_idle_err: got %b want 0", ferr_l); end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    acc_stb = 1'b1; sdrd_oe = 1'b0;
    cycle();
    acc_stb = 1'b0;
    tests++; if (ferr_l !== 1'b1) begin fails++; $display("FAIL resync_err_pulse: got %b want 1", ferr_l); end
    tests++; if (cnt_l !== 5'd0) begin fails++; $display("FAIL resync_cnt: got %0d want 0", cnt_l); end
    cycle();
    tests++; if (ferr_l !== 1'b0) begin fails++; $display("FAIL resync_err_width: got %b want 0", ferr_l); end
    send_byte(8'hFF);
    tests++; if (out_l !== 8'hFF) begin fails++; $display("FAIL resync_next_word: got %h want ff", out_l); end
    $display("[TB] test_resync byte_out=%h", out_l);
  endtask

`ifdef SEC_SDRD_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    for (int i = 0; i < 15; i++) cycle();
    tests++; if (ferr_l !== 1'b0 || cnt_l !== 5'd5) begin fails++; $display("FAIL tmo_early: err=%b cnt=%0d want 0/5", ferr_l, cnt_l); end
    cycle();
    tests++; if (ferr_l !== 1'b1) begin fails++; $display("FAIL tmo_err_pulse: got %b want 1", ferr_l); end
    tests++; if (cnt_l !== 5'd0) begin fails++; $display("FAIL tmo_cnt: got %0d want 0", cnt_l); end
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    for (int i = 0; i < 15; i++) cycle();
    send_bit(1'b1);
    tests++; if (cnt_l !== 5'd6) begin fails++; $display("FAIL tmo_strobe_wins_cnt: got %0d want 6", cnt_l); end
    tests++; if (ferr_l !== 1'b0) begin fails++; $display("FAIL tmo_strobe_wins_err: got %b want 0", ferr_l); end
    $display("[TB] test_timeout cnt=%0d", cnt_l);
  endtask
`else
  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (ferr_l !== 1'b0) begin tests++; fails++; $display("FAIL no_tmo_err: got %b want 0 at idle %0d", ferr_l, i); end
    end
    tests++; if (cnt_l !== 5'd5) begin fails++; $display("FAIL no_tmo_cnt: got %0d want 5", cnt_l); end
    $display("[TB] test_timeout (disabled) cnt=%0d", cnt_l);
  endtask
`endif

  task automatic test_rst_mid();
    do_reset();
    send_byte(8'h4D);
    send_byte(8'h11);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    tests++; if (cnt_l !== 5'd4 || valid_l !== 1'b1 || ovr_l !== 1'b1) begin fails++; $display("FAIL rst_mid_setup: cnt=%0d valid=%b ovr=%b want 4/1/1", cnt_l, valid_l, ovr_l); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    tests++; if (valid_l !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", valid_l); end
    tests++; if (cnt_l !== 5'd0) begin fails++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt_l); end
    tests++; if (ovr_l !== 1'b0) begin fails++; $display("FAIL rst_mid_overrun: got %b want 0", ovr_l); end
    tests++; if (ferr_l !== 1'b0) begin fails++; $display("FAIL rst_mid_frame_err: got %b want 0", ferr_l); end
    tests++; if (out_l !== 8'h00) begin fails++; $display("FAIL rst_mid_byte_out: got %h want 00", out_l); end
    $display("[TB] test_rst_mid done");
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_timeout();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
